// File: rtl/spi_slave.sv
// SPI slave: 2-flop synchronized ss/sclk/mosi, all four SPI modes, MSB first,
// with a one-word transmit holding register and underrun reporting.
module spi_slave #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ss,
    input  logic              sclk,
    input  logic              mosi,
    output logic              miso,
    input  logic              cpol,
    input  logic              cpha,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_load,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy,
    output logic              tx_underrun
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t              state, state_nxt;
    logic                ss_p0, ss_p1;
    logic                sclk_p0, sclk_p1, sclk_p2;
    logic                mosi_p0, mosi_p1;
    logic                fill_p0, fill_p1;
    logic                armed;
    logic                cpol_l, cpha_l;
    logic [CNT_W-1:0]    bit_cnt;
    logic [DATA_W-1:0]   rx_shift;
    logic [DATA_W-1:0]   tx_shift;
    logic [DATA_W-1:0]   hold;
    logic                start_frame, lead_edge, trail_edge;
    logic                sample_edge, update_edge, word_wrap, word_start;
    logic [DATA_W-1:0]   tx_word, rx_word;

    // Stage p0/p1: metastability filter; sclk_p2 is the edge-detect history
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ss_p0   <= 1'b1;
            ss_p1   <= 1'b1;
            sclk_p0 <= 1'b0;
            sclk_p1 <= 1'b0;
            sclk_p2 <= 1'b0;
            mosi_p0 <= 1'b0;
            mosi_p1 <= 1'b0;
            fill_p0 <= 1'b0;
            fill_p1 <= 1'b0;
        end else begin
            ss_p0   <= ss;
            ss_p1   <= ss_p0;
            sclk_p0 <= sclk;
            sclk_p1 <= sclk_p0;
            sclk_p2 <= sclk_p1;
            mosi_p0 <= mosi;
            mosi_p1 <= mosi_p0;
            fill_p0 <= 1'b1;
            fill_p1 <= fill_p0;
        end
    end

    // A frame already running when reset drops is ignored until ss is seen high
    always_ff @(posedge clk or posedge reset) begin
        if (reset) armed <= 1'b0;
        else       armed <= armed | (fill_p1 & ss_p1);
    end

    always_comb begin
        start_frame = (state == IDLE) && armed && !ss_p1;
        lead_edge   = (state == ACTIVE) && !ss_p1 && (sclk_p1 != cpol_l) && (sclk_p2 == cpol_l);
        trail_edge  = (state == ACTIVE) && !ss_p1 && (sclk_p1 == cpol_l) && (sclk_p2 != cpol_l);
        sample_edge = cpha_l ? trail_edge : lead_edge;
        update_edge = cpha_l ? lead_edge : trail_edge;
        word_wrap   = sample_edge && (bit_cnt == LAST_BIT);
        word_start  = start_frame || word_wrap;
        tx_word     = tx_ready ? '0 : hold;
        rx_word     = {rx_shift[DATA_W-2:0], mosi_p1};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_frame) state_nxt = ACTIVE;
            ACTIVE:  if (ss_p1)       state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state == ACTIVE);

    // Holding register: a word start empties it; loads are only taken when empty
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold        <= '0;
            tx_ready    <= 1'b1;
            tx_underrun <= 1'b0;
        end else begin
            tx_underrun <= word_start && tx_ready;
            if (word_start && !tx_ready) begin
                tx_ready <= 1'b1;
            end else if (tx_load && tx_ready) begin
                hold     <= tx_data;
                tx_ready <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cpol_l   <= 1'b0;
            cpha_l   <= 1'b0;
            bit_cnt  <= '0;
            rx_shift <= '0;
            tx_shift <= '0;
            miso     <= 1'b0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (state == IDLE) begin
                bit_cnt  <= '0;
                rx_shift <= '0;
                tx_shift <= '0;
                miso     <= 1'b0;
                if (start_frame) begin
                    cpol_l <= cpol;
                    cpha_l <= cpha;
                    // cpha=0 needs the MSB out before the first (sampling) edge
                    if (cpha) begin
                        tx_shift <= tx_word;
                    end else begin
                        miso     <= tx_word[DATA_W-1];
                        tx_shift <= tx_word << 1;
                    end
                end
            end else if (ss_p1) begin
                bit_cnt  <= '0;
                rx_shift <= '0;
                tx_shift <= '0;
                miso     <= 1'b0;
            end else begin
                if (sample_edge) begin
                    rx_shift <= rx_word;
                    bit_cnt  <= word_wrap ? '0 : bit_cnt + 1'b1;
                    if (word_wrap) begin
                        rx_data  <= rx_word;
                        rx_valid <= 1'b1;
                    end
                end
                if (word_wrap) begin
                    tx_shift <= tx_word;
                end else if (update_edge) begin
                    miso     <= tx_shift[DATA_W-1];
                    tx_shift <= tx_shift << 1;
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_slave.sv
// Randomized bench for spi_slave: the bench acts as SPI master and predicts
// miso, rx_data, rx_valid and tx_underrun from a word-level model of the link.
module tb_spi_slave;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset, ss, sclk, mosi, cpol, cpha, tx_load;
    logic [W-1:0] tx_data;
    logic         miso, tx_ready, rx_valid, busy, tx_underrun;
    logic [W-1:0] rx_data;

    spi_slave #(.DATA_W(W)) dut (
        .clk(clk), .reset(reset), .ss(ss), .sclk(sclk), .mosi(mosi), .miso(miso),
        .cpol(cpol), .cpha(cpha), .tx_data(tx_data), .tx_load(tx_load),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
        .busy(busy), .tx_underrun(tx_underrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Word-level model: holding register, words started in this frame, last rx word
    logic [W-1:0] m_hold;
    bit           m_empty;
    logic [W-1:0] m_last_rx;
    int           m_underruns;
    logic [W-1:0] word_q[$];
    logic [W-1:0] load_q[$];
    bit           junk_en;
    logic [63:0]  got_miso;

    int rxv_cnt = 0;
    int und_cnt = 0;
    int frame_rx0, frame_und0;

    always @(negedge clk) begin
        if (rx_valid)    rxv_cnt++;
        if (tx_underrun) und_cnt++;
    end

    task automatic model_start();
        if (m_empty) begin
            word_q.push_back('0);
            m_underruns++;
        end else begin
            word_q.push_back(m_hold);
            m_empty = 1'b1;
        end
    endtask

    // Half an sclk period (8 clk); loads the next word when the model says the holder is empty
    task automatic half(input bit exp_rx);
        int seen;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (c < 5 && rx_valid) seen++;
            if (c == 4) begin
                check("tx_ready", tx_ready, m_empty);
                if (load_q.size() > 0 && m_empty) begin
                    tx_data = load_q.pop_front();
                    tx_load = 1'b1;
                    m_hold  = tx_data;
                    m_empty = 1'b0;
                end else if (junk_en && !m_empty && $urandom_range(0, 2) == 0) begin
                    tx_data = W'($urandom);
                    tx_load = 1'b1;
                end
            end
            if (c == 5) tx_load = 1'b0;
        end
        check("rx_valid_latency", seen, exp_rx ? 1 : 0);
    endtask

    task automatic run_frame(input bit pol, input bit pha, input int nbits, input logic [63:0] mbits);
        int           nw;
        logic [W-1:0] w;
        cpol = pol; cpha = pha; sclk = pol; ss = 1'b1; mosi = 1'b0;
        half(1'b0);
        half(1'b0);
        frame_rx0 = rxv_cnt; frame_und0 = und_cnt;
        m_underruns = 0; word_q.delete(); got_miso = '0;
        ss = 1'b0;
        model_start();
        if (!pha) mosi = mbits[nbits-1];
        half(1'b0);
        check("busy", busy, 1);
        // mode pins moved mid-frame must have no effect
        cpol = ~pol; cpha = ~pha;
        for (int i = 0; i < nbits; i++) begin
            bit wrap;
            wrap = ((i + 1) % W) == 0;
            if (pha) begin
                sclk = ~pol;
                mosi = mbits[nbits-1-i];
                half(1'b0);
            end
            w = word_q[i / W];
            check("miso", miso, w[W-1-(i%W)]);
            got_miso = {got_miso[62:0], miso};
            sclk = pha ? pol : ~pol;
            if (wrap) model_start();
            half(wrap);
            if (!pha) begin
                sclk = pol;
                if (i + 1 < nbits) mosi = mbits[nbits-2-i];
                half(1'b0);
            end
        end
        ss = 1'b1; cpol = pol; cpha = pha;
        half(1'b0);
        half(1'b0);
        nw = nbits / W;
        check("busy_idle", busy, 0);
        check("miso_idle", miso, 0);
        check("rx_valid_count", rxv_cnt - frame_rx0, nw);
        check("underrun_count", und_cnt - frame_und0, m_underruns);
        if (nw > 0) m_last_rx = mbits[nbits-1-(nw-1)*W -: W];
        check("rx_data", rx_data, m_last_rx);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [63:0] mb;
        reset = 1'b1; ss = 1'b1; sclk = 1'b0; mosi = 1'b0; cpol = 1'b0; cpha = 1'b0;
        tx_load = 1'b0; tx_data = '0; junk_en = 1'b0;
        m_empty = 1'b1; m_hold = '0; m_last_rx = '0; m_underruns = 0;
        @(negedge clk); @(negedge clk);
        check("rst_tx_ready", tx_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_miso", miso, 0);
        check("rst_rx_data", rx_data, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_underrun", tx_underrun, 0);
        reset = 1'b0;

        // mode 0
        load_q.push_back(8'hA5);
        run_frame(1'b0, 1'b0, 8, 64'h3C);
        check("m0_miso_word", got_miso[7:0], 8'hA5);
        check("m0_rx_data", rx_data, 8'h3C);
        check("m0_pulses", rxv_cnt - frame_rx0, 1);

        // mode 3
        load_q.push_back(8'h81);
        run_frame(1'b1, 1'b1, 8, 64'hF0);
        check("m3_miso_word", got_miso[7:0], 8'h81);
        check("m3_rx_data", rx_data, 8'hF0);

        // back to back; the third word keeps the holder fed through the final wrap
        load_q.push_back(8'h12); load_q.push_back(8'h34); load_q.push_back(8'h56);
        run_frame(1'b0, 1'b0, 16, 64'hBEEF);
        check("b2b_miso", got_miso[15:0], 16'h1234);
        check("b2b_pulses", rxv_cnt - frame_rx0, 2);
        check("b2b_underrun", und_cnt - frame_und0, 0);
        check("b2b_rx_data", rx_data, 8'hEF);

        // underrun: one word loaded for a two-word frame
        load_q.push_back(8'hC3);
        run_frame(1'b0, 1'b1, 16, 64'h5A5A);
        check("udr_word1", got_miso[15:8], 8'hC3);
        check("udr_word2", got_miso[7:0], 8'h00);
        check("udr_pulses", und_cnt - frame_und0, 2);

        // ss abort after 5 bits, then a clean frame
        load_q.push_back(8'h77);
        run_frame(1'b1, 1'b0, 5, 64'h1F);
        check("abort_pulses", rxv_cnt - frame_rx0, 0);
        check("abort_rx_hold", rx_data, 8'h5A);
        mb = {$urandom, $urandom};
        run_frame(1'b1, 1'b0, 8, mb);
        check("post_abort_rx", rx_data, mb[7:0]);

        // reset in the middle of a frame
        load_q.push_back(8'hFF);
        cpol = 1'b0; cpha = 1'b0; sclk = 1'b0; ss = 1'b1; mosi = 1'b1;
        half(1'b0); half(1'b0);
        word_q.delete();
        ss = 1'b0;
        model_start();
        half(1'b0);
        for (int i = 0; i < 3; i++) begin
            sclk = 1'b1; half(1'b0);
            sclk = 1'b0; half(1'b0);
        end
        #2 reset = 1'b1;
        #1;
        check("mid_rst_miso", miso, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_tx_ready", tx_ready, 1);
        check("mid_rst_rx_data", rx_data, 0);
        check("mid_rst_rx_valid", rx_valid, 0);
        check("mid_rst_underrun", tx_underrun, 0);
        @(negedge clk);
        reset = 1'b0;
        m_empty = 1'b1; m_last_rx = '0; load_q.delete();
        frame_rx0 = rxv_cnt;
        for (int i = 0; i < 8; i++) begin
            sclk = 1'b1; half(1'b0);
            check("ignored_busy", busy, 0);
            sclk = 1'b0; half(1'b0);
        end
        check("ignored_rx", rxv_cnt - frame_rx0, 0);
        check("ignored_rx_data", rx_data, 0);
        ss = 1'b1;
        mb = {$urandom, $urandom};
        run_frame(1'b0, 1'b1, 8, mb);
        check("post_rst_rx", rx_data, mb[7:0]);

        // randomized frames with junk loads while the holder is full
        junk_en = 1'b1;
        for (int f = 0; f < 14; f++) begin
            int nl;
            nl = $urandom_range(0, 3);
            for (int k = 0; k < nl; k++) load_q.push_back(W'($urandom));
            mb = {$urandom, $urandom};
            run_frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(1, 24), mb);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
